// File: rtl/state_sequencer.sv
// Multicycle control sequencer: walks fetch/decode/execute states, stalls memory
// states on memready, and tracks a sticky illegal-opcode flag and a retire count.
module state_sequencer #(
  parameter int RETIRE_W     = 16,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                memready,
  input  logic                pcwrite,
  input  logic                branch,
  output logic [3:0]          state,
  output logic                pcen,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_UNUSED = 4'd0,
    FETCH1   = 4'd1,
    FETCH2   = 4'd2,
    FETCH3   = 4'd3,
    FETCH4   = 4'd4,
    DECODE   = 4'd5,
    MEMADR   = 4'd6,
    LBRD     = 4'd7,
    LBWR     = 4'd8,
    SBWR     = 4'd9,
    RTYPEEX  = 4'd10,
    RTYPEWR  = 4'd11,
    BEQEX    = 4'd12,
    JEX      = 4'd13,
    ADDIWR   = 4'd14,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t                r_state;
  state_t                w_next;
  logic                  r_illegal;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  w_isMem;
  logic                  w_adv;
  logic                  w_retire;
  logic                  w_setIllegal;

  // adv is low only while a memory state waits on memready.
  always_comb begin
    w_isMem = (r_state == FETCH1) || (r_state == FETCH2) || (r_state == FETCH3) ||
              (r_state == FETCH4) || (r_state == LBRD)   || (r_state == SBWR);
    w_adv   = !w_isMem || memready;
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_setIllegal = 1'b0;
    case (r_state)
      FETCH1:  if (memready) w_next = FETCH2;
      FETCH2:  if (memready) w_next = FETCH3;
      FETCH3:  if (memready) w_next = FETCH4;
      FETCH4:  if (memready) w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB, OP_ADDI: w_next = MEMADR;
          OP_RTYPE:              w_next = RTYPEEX;
          OP_BEQ:                w_next = BEQEX;
          OP_J:                  w_next = JEX;
          default: begin
            w_setIllegal = 1'b1;
            w_next       = ILLEGAL_HALT ? HALT : FETCH1;
          end
        endcase
      end
      MEMADR: begin
        case (op)
          OP_LB:   w_next = LBRD;
          OP_SB:   w_next = SBWR;
          OP_ADDI: w_next = ADDIWR;
          default: w_next = FETCH1;
        endcase
      end
      LBRD:    if (memready) w_next = LBWR;
      SBWR: begin
        if (memready) begin
          w_next   = FETCH1;
          w_retire = 1'b1;
        end
      end
      RTYPEEX: w_next = RTYPEWR;
      LBWR, RTYPEWR, BEQEX, JEX, ADDIWR: begin
        w_next   = FETCH1;
        w_retire = 1'b1;
      end
      HALT:    w_next = HALT;
      default: w_next = FETCH1;
    endcase
  end

  // Gating with reset keeps pcen low during the asynchronous reset window.
  always_comb begin
    pcen = reset && (r_state != HALT) && ((pcwrite && w_adv) || (branch && zero));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH1;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_setIllegal) r_illegal <= 1'b1;
      if (w_retire)     r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: two instances (halting/16-bit, non-halting/4-bit)
// checked against an instruction-path reference model.
module tb_state_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = 6'd0;
  logic        zero = 1'b0;
  logic        memready = 1'b0;
  logic        pcwrite = 1'b0;
  logic        branch = 1'b0;

  logic [3:0]  s0, s1;
  logic        pcen0, pcen1, ill0, ill1;
  logic [15:0] ret0;
  logic [3:0]  ret1;

  int vectors = 0;
  int miscompares = 0;

  int mIdx[2];
  int mRet[2];
  bit mIll[2];
  bit mHalted[2];

  state_sequencer #(.RETIRE_W(16), .ILLEGAL_HALT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
    .pcwrite(pcwrite), .branch(branch), .state(s0), .pcen(pcen0),
    .illegal(ill0), .retired(ret0)
  );

  state_sequencer #(.RETIRE_W(4), .ILLEGAL_HALT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
    .pcwrite(pcwrite), .branch(branch), .state(s1), .pcen(pcen1),
    .illegal(ill1), .retired(ret1)
  );

  always #5 clk = ~clk;

  // Instruction classes: 0 LB, 1 SB, 2 RTYPE, 3 BEQ, 4 J, 5 ADDI, 6 illegal.
  function automatic int opClass(logic [5:0] o);
    case (o)
      6'b100000: return 0;
      6'b101000: return 1;
      6'b000000: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000: return 5;
      default:   return 6;
    endcase
  endfunction

  // Each legal instruction is a fixed list of state codes starting at fetch.
  function automatic int pathAt(logic [5:0] o, int idx);
    if (idx < 5) return idx + 1;
    case (opClass(o))
      0:       return (idx == 5) ? 6 : ((idx == 6) ? 7 : 8);
      1:       return (idx == 5) ? 6 : 9;
      2:       return (idx == 5) ? 10 : 11;
      3:       return 12;
      4:       return 13;
      5:       return (idx == 5) ? 6 : 14;
      default: return 0;
    endcase
  endfunction

  function automatic int pathLen(logic [5:0] o);
    case (opClass(o))
      0:       return 8;
      1, 2, 5: return 7;
      3, 4:    return 6;
      default: return 5;
    endcase
  endfunction

  function automatic bit isMemCode(int s);
    return (s >= 1 && s <= 4) || s == 7 || s == 9;
  endfunction

  function automatic int expState(int i);
    return mHalted[i] ? 15 : pathAt(op, mIdx[i]);
  endfunction

  function automatic bit expPcen(int i);
    bit adv;
    if (!reset || mHalted[i]) return 1'b0;
    adv = !isMemCode(expState(i)) || memready;
    return (pcwrite && adv) || (branch && zero);
  endfunction

  function automatic logic [21:0] expVec(int i);
    logic [15:0] r;
    r = (i == 0) ? 16'(mRet[i]) : {12'd0, 4'(mRet[i])};
    return {4'(expState(i)), expPcen(i), mIll[i], r};
  endfunction

  function automatic logic [21:0] obsVec(int i);
    return (i == 0) ? {s0, pcen0, ill0, ret0} : {s1, pcen1, ill1, 12'd0, ret1};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mIdx[i] = 0; mRet[i] = 0; mIll[i] = 1'b0; mHalted[i] = 1'b0;
    end
  endtask

  task automatic modelAdvance(int i);
    if (!reset) begin
      mIdx[i] = 0; mRet[i] = 0; mIll[i] = 1'b0; mHalted[i] = 1'b0;
      return;
    end
    if (mHalted[i]) return;
    if (isMemCode(expState(i)) && !memready) return;
    if (mIdx[i] == 4 && opClass(op) == 6) begin
      mIll[i] = 1'b1;
      if (i == 0) mHalted[i] = 1'b1;
      mIdx[i] = 0;
      return;
    end
    mIdx[i]++;
    if (mIdx[i] == pathLen(op)) begin
      mIdx[i] = 0;
      mRet[i]++;
    end
  endtask

  // Inputs change just after a falling edge; the model steps with the rising edge.
  task automatic tick();
    modelAdvance(0);
    modelAdvance(1);
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    #1 modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pcwrite = 1'b1; branch = 1'b1; zero = 1'b1; memready = 1'b1; op = 6'd0;
    #1 modelReset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obsVec(i) !== expVec(i)) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %h want %h", i, obsVec(i), expVec(i));
      end
    end
    vectors++;
    if (s0 !== 4'd1 || pcen0 !== 1'b0 || ret0 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_values: got st=%0d pcen=%0d ret=%0d want st=1 pcen=0 ret=0", s0, pcen0, ret0);
    end
    @(negedge clk);
    reset = 1'b1; memready = 1'b0; branch = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL reset_stall dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_rtype();
    int seq[8] = '{1, 2, 3, 4, 5, 10, 11, 1};
    applyReset();
    op = 6'b000000; memready = 1'b1; pcwrite = 1'b1; branch = 1'b0; zero = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (s0 !== 4'(seq[c])) begin
        miscompares++;
        $display("FAIL rtype_seq c%0d: got %0d want %0d", c, s0, seq[c]);
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL rtype dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      if (c < 7) tick();
    end
    vectors++;
    if (ret0 !== 16'd1) begin
      miscompares++;
      $display("FAIL rtype_retired: got %0d want 1", ret0);
    end
  endtask

  task automatic test_lb_stall();
    applyReset();
    op = 6'b100000; memready = 1'b1; pcwrite = 1'b1; branch = 1'b0;
    for (int c = 0; c < 12; c++) begin
      memready = (c >= 6 && c < 9) ? 1'b0 : 1'b1;
      #1;
      if (c >= 6 && c < 9) begin
        vectors++;
        if (s0 !== 4'd7 || pcen0 !== 1'b0) begin
          miscompares++;
          $display("FAIL lb_hold c%0d: got st=%0d pcen=%0d want st=7 pcen=0", c, s0, pcen0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL lb_stall dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_beq();
    applyReset();
    op = 6'b000100; memready = 1'b1; pcwrite = 1'b0; branch = 1'b1;
    for (int c = 0; c < 12; c++) begin
      zero = (c < 6) ? 1'b1 : 1'b0;
      #1;
      if (c == 5 || c == 11) begin
        vectors++;
        if (s0 !== 4'd12 || pcen0 !== zero) begin
          miscompares++;
          $display("FAIL beq_pcen c%0d: got st=%0d pcen=%0d want st=12 pcen=%0d", c, s0, pcen0, zero);
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL beq dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      tick();
    end
    vectors++;
    if (ret0 !== 16'd2) begin
      miscompares++;
      $display("FAIL beq_retired: got %0d want 2", ret0);
    end
  endtask

  task automatic test_illegal();
    applyReset();
    op = 6'b111111; memready = 1'b1; pcwrite = 1'b1; branch = 1'b1; zero = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL illegal dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      tick();
    end
    #1;
    vectors++;
    if (s0 !== 4'd15 || ill0 !== 1'b1 || pcen0 !== 1'b0 || ill1 !== 1'b1 || ret1 !== 4'd0) begin
      miscompares++;
      $display("FAIL illegal_halt: got st=%0d ill=%0d pcen=%0d ill1=%0d ret1=%0d want 15 1 0 1 0",
               s0, ill0, pcen0, ill1, ret1);
    end
    reset = 1'b0;
    #1 modelReset();
    vectors++;
    if (s0 !== 4'd1 || ill0 !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_reset: got st=%0d ill=%0d want st=1 ill=0", s0, ill0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    applyReset();
    op = 6'b000010; memready = 1'b1; pcwrite = 1'b0; branch = 1'b0;
    for (int c = 0; c < 96; c++) begin
      pcwrite = 1'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL wrap dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      tick();
    end
    #1;
    vectors++;
    if (ret1 !== 4'd0 || ret0 !== 16'd16) begin
      miscompares++;
      $display("FAIL wrap_final: got ret1=%0d ret0=%0d want 0 and 16", ret1, ret0);
    end
  endtask

  task automatic test_reset_stall();
    logic [15:0] preRet;
    applyReset();
    op = 6'b101000; memready = 1'b1; pcwrite = 1'b1;
    for (int c = 0; c < 9; c++) begin
      memready = (c < 6) ? 1'b1 : 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL sb_stall dut%0d c%0d: got %h want %h", i, c, obsVec(i), expVec(i));
        end
      end
      tick();
    end
    #1;
    preRet = ret0;
    vectors++;
    if (s0 !== 4'd9 || preRet !== 16'd0) begin
      miscompares++;
      $display("FAIL sb_held: got st=%0d ret=%0d want st=9 ret=0", s0, preRet);
    end
    #2 reset = 1'b0;
    #1 modelReset();
    vectors++;
    if (s0 !== 4'd1 || s1 !== 4'd1 || ret0 !== 16'd0 || pcen0 !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_abort: got st=%0d/%0d ret=%0d pcen=%0d want 1/1 0 0", s0, s1, ret0, pcen0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] legal[6] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    applyReset();
    for (int c = 0; c < 400; c++) begin
      if (mIdx[0] == 0 && mIdx[1] == 0) op = legal[$urandom_range(0, 5)];
      memready = ($urandom_range(0, 3) != 0);
      pcwrite  = 1'($urandom);
      branch   = 1'($urandom);
      zero     = 1'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obsVec(i) !== expVec(i)) begin
          miscompares++;
          $display("FAIL random dut%0d c%0d op=%b: got %h want %h", i, c, op, obsVec(i), expVec(i));
        end
      end
      tick();
    end
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    test_reset();
    test_rtype();
    test_lb_stall();
    test_beq();
    test_illegal();
    test_wrap();
    test_reset_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
